// File: rtl/phy_reset_seq_pkg.sv
// rtl/phy_reset_seq_pkg.sv - shared width constant and saturating counter helper for the PHY reset sequencer
package phy_reset_seq_pkg;

  localparam int unsigned RST_COUNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
    sat_inc = (v == {RST_COUNT_W{1'b1}}) ? v : v + RST_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/phy_reset_seq.sv
// rtl/phy_reset_seq.sv - Ethernet PHY reset pulse and settle sequencer with software re-reset
module phy_reset_seq
  import phy_reset_seq_pkg::*;
#(
  parameter int unsigned RST_ASSERT_CYCLES = 1250000,
  parameter int unsigned RST_WAIT_CYCLES   = 6250
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   soft_rst_req,
  output logic                   phy_reset_n,
  output logic                   phy_ready,
  output logic                   busy,
  output logic [RST_COUNT_W-1:0] rst_count
);

  localparam logic [1:0] S_ASSERT = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  // One counter serves both phases, so it is sized for the longer one
  localparam int unsigned CNT_MAX = (RST_ASSERT_CYCLES > RST_WAIT_CYCLES) ? RST_ASSERT_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(RST_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(RST_WAIT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RST_COUNT_W-1:0] rst_count_q, rst_count_d;
  logic                   phy_reset_n_q, phy_reset_n_d;
  logic                   phy_ready_q, phy_ready_d;
  logic                   busy_q, busy_d;

  // State, counter and output registers; resetn forces the start of a fresh sequence
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_ASSERT;
      cnt_q         <= ASSERT_LOAD;
      rst_count_q   <= '0;
      phy_reset_n_q <= 1'b0;
      phy_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_count_q   <= rst_count_d;
      phy_reset_n_q <= phy_reset_n_d;
      phy_ready_q   <= phy_ready_d;
      busy_q        <= busy_d;
    end
  end

  // Next state and counter; a software request outranks any terminal count
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_count_d = rst_count_q;
    case (state_q)
      S_ASSERT: begin
        if (soft_rst_req) begin
          cnt_d = ASSERT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (soft_rst_req) begin
          state_d = S_ASSERT;
          cnt_d   = ASSERT_LOAD;
        end else if (cnt_q == '0) begin
          state_d     = S_READY;
          rst_count_d = sat_inc(rst_count_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READY: begin
        if (soft_rst_req) begin
          state_d = S_ASSERT;
          cnt_d   = ASSERT_LOAD;
        end
      end
      default: begin
        state_d = S_ASSERT;
        cnt_d   = ASSERT_LOAD;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_q
  always_comb begin
    phy_reset_n_d = (state_d != S_ASSERT);
    phy_ready_d   = (state_d == S_READY);
    busy_d        = (state_d != S_READY);
  end

  assign phy_reset_n = phy_reset_n_q;
  assign phy_ready   = phy_ready_q;
  assign busy        = busy_q;
  assign rst_count   = rst_count_q;

endmodule

// File: doc/phy_reset_seq.md
PHY_RESET_SEQ -- requirements
Module: phy_reset_seq

Interface
REQ-001 SHALL have parameter RST_ASSERT_CYCLES, default 1250000, meaning the PHY reset low time in clk cycles (10 ms at 125 MHz); legal range is at least 1.
REQ-002 SHALL have parameter RST_WAIT_CYCLES, default 6250, meaning the settle time after PHY reset release before ready (50 us at 125 MHz); legal range is at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port soft_rst_req, input, 1 bit: single-cycle software request to re-reset the PHY.
REQ-006 SHALL have port phy_reset_n, output, 1 bit: active-low reset to the Ethernet PHY pin, registered.
REQ-007 SHALL have port phy_ready, output, 1 bit: high when the PHY is out of reset and settled, so the MAC may be released; registered.
REQ-008 SHALL have port busy, output, 1 bit: high in any state other than READY; registered.
REQ-009 SHALL have port rst_count, output, 8 bits: number of completed reset sequences, saturating at 255.

Function
REQ-010 SHALL implement a three-state FSM: ASSERT, WAIT, READY.
REQ-011 In ASSERT, phy_reset_n SHALL be 0, phy_ready 0 and busy 1.
REQ-012 In WAIT, phy_reset_n SHALL be 1, phy_ready 0 and busy 1.
REQ-013 In READY, phy_reset_n SHALL be 1, phy_ready 1 and busy 0.
REQ-014 One down-counter SHALL be used, sized to the larger of the two parameters via clog2.
REQ-015 On entry to ASSERT the counter SHALL load RST_ASSERT_CYCLES-1; on entry to WAIT it SHALL load RST_WAIT_CYCLES-1.
REQ-016 ASSERT SHALL transition to WAIT when the counter is 0 and SHALL otherwise decrement, so phy_reset_n is low for exactly RST_ASSERT_CYCLES cycles.
REQ-017 WAIT SHALL transition to READY when the counter is 0, so phy_reset_n high to phy_ready high takes exactly RST_WAIT_CYCLES cycles.
REQ-018 On the WAIT-to-READY transition, rst_count SHALL increment by 1, saturating at 255 with no wrap.
REQ-019 soft_rst_req in READY SHALL move the FSM to ASSERT on the next edge and reload the counter; phy_reset_n SHALL fall 1 cycle after the request.
REQ-020 soft_rst_req in WAIT SHALL abort WAIT and re-enter ASSERT with the counter reloaded; rst_count SHALL NOT increment.
REQ-021 soft_rst_req in ASSERT SHALL reload the counter, extending the low time to RST_ASSERT_CYCLES counted from the last request.
REQ-022 When soft_rst_req coincides with a counter-0 terminal condition, soft_rst_req SHALL win.
REQ-023 soft_rst_req held high for several cycles SHALL behave as a request on every such cycle, so the PHY stays in reset until it drops.
REQ-024 The outputs SHALL be decoded from registered state through registered output flops, with no combinational path from soft_rst_req to any output.

Reset
REQ-025 While resetn=0, the FSM SHALL be ASSERT, the counter RST_ASSERT_CYCLES-1, phy_reset_n 0, phy_ready 0, busy 1 and rst_count 0, all asynchronously.
REQ-026 After resetn rises, counting SHALL begin on the first rising clk edge, giving phy_reset_n low for RST_ASSERT_CYCLES edges.
REQ-027 resetn asserted mid-sequence (any state) SHALL immediately force the REQ-025 values.

Structure
REQ-028 FSM state encodings SHALL be localparams local to the module; no shared package is required.
REQ-029 The block SHALL be flat, with no sub-module; it is instantiated in the chip top between reset_gen and top, driving PHY_RESET and gating the MAC reset with phy_ready.

Verification (RST_ASSERT_CYCLES=8, RST_WAIT_CYCLES=4)
REQ-030 Release resetn -> phy_reset_n low exactly 8 edges, then high; phy_ready high exactly 4 edges later; rst_count=1.
REQ-031 Pulse soft_rst_req 1 cycle in READY -> phy_reset_n low the next cycle for 8 cycles, ready 4 cycles after release, rst_count=2.
REQ-032 Pulse soft_rst_req at the 2nd WAIT cycle -> back to ASSERT with a full 8-cycle low time; rst_count unchanged until completion.
REQ-033 Pulse soft_rst_req in ASSERT at counter=0 -> ASSERT is extended (total low time of 8 cycles from the pulse); no WAIT entry that cycle.
REQ-034 Run 260 soft-reset sequences -> rst_count saturates at 255.
REQ-035 Assert resetn mid-WAIT for 1 cycle -> outputs immediately take the REQ-025 values; the full sequence restarts and rst_count=0.
